// File: rtl/rs_syndrome_stream_pkg.sv
// Shared GF(2^M) helpers for the streaming RS syndrome front end.
// Field arithmetic is generic in M/PRIM; the functions run at elaboration time or unroll into XOR trees.
`timescale 1ns/1ps
package rs_syndrome_stream_pkg;

    localparam int unsigned GF_MAX_M = 16;

    typedef logic [GF_MAX_M-1:0] gf_elem_t;

    // Shift-and-reduce multiply, MSB of b first; only the low m bits are meaningful.
    function automatic gf_elem_t gf_mul(input gf_elem_t a, input gf_elem_t b,
                                        input int unsigned m, input int unsigned prim);
        gf_elem_t r;
        gf_elem_t p;
        p = gf_elem_t'(prim);
        r = '0;
        for (int unsigned k = 0; k < GF_MAX_M; k++) begin
            if ((GF_MAX_M - 1 - k) < m) begin
                r = r << 1;
                if (r[m]) r = r ^ p;
                if (b[GF_MAX_M - 1 - k]) r = r ^ a;
            end
        end
        return r;
    endfunction

    function automatic gf_elem_t alpha_pow(input int unsigned e, input int unsigned m,
                                           input int unsigned prim);
        gf_elem_t r;
        int unsigned order;
        int unsigned ee;
        order = (32'd1 << m) - 32'd1;
        ee = e % order;
        r = gf_elem_t'(1);
        for (int unsigned k = 0; k < ee; k++) begin
            r = gf_mul(r, gf_elem_t'(2), m, prim);
        end
        return r;
    endfunction

endpackage

// File: rtl/rs_syndrome_stream_gf_const_mul.sv
// Combinational multiply by a fixed GF(2^M) element; each input bit selects one precomputed column.
`timescale 1ns/1ps
module rs_syndrome_stream_gf_const_mul
    import rs_syndrome_stream_pkg::*;
#(
    parameter int unsigned M     = 3,
    parameter int unsigned PRIM  = 'hB,
    parameter int unsigned CONST = 1
) (
    input  logic [M-1:0] a,
    output logic [M-1:0] y
);

    always_comb begin
        y = '0;
        for (int unsigned i = 0; i < M; i++) begin
            if (a[i]) y = y ^ M'(gf_mul(gf_elem_t'(CONST), gf_elem_t'(1) << i, M, PRIM));
        end
    end

endmodule

// File: rtl/rs_syndrome_stream.sv
// Streaming RS(N,N-2T) syndrome generator: Horner accumulation per syndrome, one symbol per cycle,
// with a double-buffered output register so consecutive codewords run at full rate.
`timescale 1ns/1ps
module rs_syndrome_stream
    import rs_syndrome_stream_pkg::*;
#(
    parameter int unsigned M    = 3,
    parameter int unsigned N    = 7,
    parameter int unsigned T    = 2,
    parameter int unsigned PRIM = 'hB,
    parameter int unsigned FCR  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [M-1:0]     in_sym,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*T*M-1:0] syn_out,
    output logic             syn_zero,
    output logic             frame_err
);

    localparam int unsigned NS = 2 * T;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    logic [CW-1:0]     sym_cnt;
    logic [M-1:0]      acc  [NS];
    logic [M-1:0]      prod [NS];
    logic [NS*M-1:0]   nxt_vec;
    logic              err_acc;
    logic              first;
    logic              last;
    logic              accept;
    logic              word_err;

    for (genvar j = 0; j < NS; j++) begin : g_root
        rs_syndrome_stream_gf_const_mul #(
            .M    (M),
            .PRIM (PRIM),
            .CONST(32'(alpha_pow(j + FCR, M, PRIM)))
        ) u_mul (
            .a(acc[j]),
            .y(prod[j])
        );
    end

    // Only the closing symbol waits for the output register; earlier symbols never touch it.
    always_comb begin
        first    = (sym_cnt == '0);
        last     = (sym_cnt == CW'(N - 1));
        in_ready = enable & ~(last & out_valid & ~out_ready);
        accept   = in_valid & in_ready;
        word_err = (first ? 1'b0 : err_acc) | (in_last != last);
        nxt_vec  = '0;
        for (int unsigned j = 0; j < NS; j++) begin
            nxt_vec[j*M +: M] = first ? in_sym : (prod[j] ^ in_sym);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sym_cnt   <= '0;
            err_acc   <= 1'b0;
            out_valid <= 1'b0;
            syn_out   <= '0;
            syn_zero  <= 1'b0;
            frame_err <= 1'b0;
            for (int unsigned j = 0; j < NS; j++) acc[j] <= '0;
        end else begin
            if (accept) begin
                sym_cnt <= last ? '0 : sym_cnt + CW'(1);
                err_acc <= word_err;
                for (int unsigned j = 0; j < NS; j++) acc[j] <= nxt_vec[j*M +: M];
            end
            // A closing load takes priority over the drain so back-to-back words leave no bubble.
            if (accept && last) begin
                out_valid <= 1'b1;
                syn_out   <= nxt_vec;
                syn_zero  <= ~|nxt_vec;
                frame_err <= word_err;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rs_syndrome_stream.sv
// Scoreboard bench for rs_syndrome_stream at defaults RS(7,3) over GF(8), x^3+x+1, FCR=1.
`timescale 1ns/1ps
module tb_rs_syndrome_stream;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_sym;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] syn_out;
    logic        syn_zero;
    logic        frame_err;

    typedef struct packed {
        logic [11:0] syn;
        logic        zero;
        logic        ferr;
    } exp_t;

    exp_t    sb[$];
    longint  pop_times[$];
    exp_t    mon_e;
    int      errors = 0;
    int      checks = 0;

    rs_syndrome_stream #(.M(3), .N(7), .T(2), .PRIM('hB), .FCR(1)) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_sym   (in_sym),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .syn_out  (syn_out),
        .syn_zero (syn_zero),
        .frame_err(frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] pk(input logic [2:0] s0, input logic [2:0] s1,
                                       input logic [2:0] s2, input logic [2:0] s3);
        return {s3, s2, s1, s0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push(input logic [11:0] syn, input logic zero, input logic ferr);
        exp_t e;
        e.syn  = syn;
        e.zero = zero;
        e.ferr = ferr;
        sb.push_back(e);
    endtask

    // Monitor: handshake seen at the negedge completes on the following posedge.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output actual=%0h required=none", syn_out);
            end else begin
                mon_e = sb.pop_front();
                check("syn_out", 32'(syn_out), 32'(mon_e.syn));
                check("syn_zero", 32'(syn_zero), 32'(mon_e.zero));
                check("frame_err", 32'(frame_err), 32'(mon_e.ferr));
                pop_times.push_back($time);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the symbol was accepted.
    task automatic put(input logic [2:0] s, input logic l, output bit stalled);
        in_valid = 1'b1;
        in_sym   = s;
        in_last  = l;
        stalled  = 1'b0;
        #1;
        for (int w = 0; !in_ready; w++) begin
            if (w >= 20) begin
                checks++;
                errors++;
                $display("FAIL put_timeout actual=stalled required=accept");
                in_valid = 1'b0;
                return;
            end
            stalled = 1'b1;
            @(posedge clk);
            #2;
        end
        @(posedge clk);
        #1;
    endtask

    // w[20:18] is the first (highest-degree) symbol.
    task automatic send_word(input logic [20:0] w, input int last_pos, output int stalls);
        bit st;
        stalls = 0;
        for (int k = 0; k < 7; k++) begin
            put(w[(6-k)*3 +: 3], k == last_pos, st);
            if (st) stalls++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        for (int w = 0; sb.size() != 0; w++) begin
            if (w >= 30) begin
                checks++;
                errors++;
                $display("FAIL drain_timeout actual=%0d required=0", sb.size());
                sb.delete();
                return;
            end
            @(posedge clk);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  stalls;
        int  total;
        int  base;
        bit  st;

        reset     = 1'b1;
        enable    = 1'b1;
        in_valid  = 1'b0;
        in_sym    = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(out_valid), 0);
        check("reset_syn_out", 32'(syn_out), 0);
        check("reset_syn_zero", 32'(syn_zero), 0);
        check("reset_frame_err", 32'(frame_err), 0);
        reset = 1'b0;
        #1;
        check("idle_in_ready", 32'(in_ready), 1);
        @(posedge clk);
        #1;

        // 1: all-zero word; output appears one cycle after the closing symbol
        push(12'h000, 1'b1, 1'b0);
        send_word(21'd0, 6, stalls);
        check("latency_out_valid", 32'(out_valid), 1);
        drain();

        // 2: x^6 only -> 5,7,6,3
        push(pk(3'd5, 3'd7, 3'd6, 3'd3), 1'b0, 1'b0);
        send_word({3'd1, 18'd0}, 6, stalls);
        drain();

        // 3: constant term 3 -> 3,3,3,3, with an enable=0 gap that must freeze state
        push(pk(3'd3, 3'd3, 3'd3, 3'd3), 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) put(3'd0, 1'b0, st);
        enable   = 1'b0;
        in_valid = 1'b1;
        in_sym   = 3'd7;
        #1;
        check("disabled_in_ready", 32'(in_ready), 0);
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        enable   = 1'b1;
        for (int k = 3; k < 6; k++) put(3'd0, 1'b0, st);
        put(3'd3, 1'b1, st);
        in_valid = 1'b0;
        in_last  = 1'b0;
        drain();

        // 4: back-to-back x^1, x^2, x^6 at full rate
        base = pop_times.size();
        push(pk(3'd2, 3'd4, 3'd3, 3'd6), 1'b0, 1'b0);
        push(pk(3'd4, 3'd6, 3'd5, 3'd2), 1'b0, 1'b0);
        push(pk(3'd5, 3'd7, 3'd6, 3'd3), 1'b0, 1'b0);
        total = 0;
        send_word({15'd0, 3'd1, 3'd0}, 6, stalls);
        total += stalls;
        send_word({12'd0, 3'd1, 6'd0}, 6, stalls);
        total += stalls;
        send_word({3'd1, 18'd0}, 6, stalls);
        total += stalls;
        check("b2b_stalls", 32'(total), 0);
        drain();
        if (pop_times.size() >= base + 3) begin
            check("b2b_spacing_1", 32'(pop_times[base+1] - pop_times[base]), 70);
            check("b2b_spacing_2", 32'(pop_times[base+2] - pop_times[base+1]), 70);
        end else begin
            check("b2b_pop_count", 32'(pop_times.size() - base), 3);
        end

        // 5: output held while downstream stalls; only the closing symbol waits
        out_ready = 1'b0;
        push(pk(3'd7, 3'd3, 3'd5, 3'd5), 1'b0, 1'b0);
        send_word({3'd1, 12'd0, 3'd1, 3'd0}, 6, stalls);
        push(pk(3'd4, 3'd6, 3'd5, 3'd2), 1'b0, 1'b0);
        total = 0;
        for (int k = 0; k < 6; k++) begin
            put((k == 4) ? 3'd1 : 3'd0, 1'b0, st);
            if (st) total++;
        end
        check("stream_while_held", 32'(total), 0);
        in_valid = 1'b1;
        in_sym   = 3'd0;
        in_last  = 1'b1;
        #1;
        check("closing_stall", 32'(in_ready), 0);
        repeat (2) @(posedge clk);
        #1;
        check("hold_out_valid", 32'(out_valid), 1);
        check("hold_syn_out", 32'(syn_out), 32'(pk(3'd7, 3'd3, 3'd5, 3'd5)));
        out_ready = 1'b1;
        #1;
        check("release_in_ready", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("load_wins", 32'(out_valid), 1);
        drain();

        // 6: early in_last flags only its own word; reset drops partial word and unread output
        push(12'h000, 1'b1, 1'b1);
        send_word(21'd0, 4, stalls);
        push(pk(3'd2, 3'd4, 3'd3, 3'd6), 1'b0, 1'b0);
        send_word({15'd0, 3'd1, 3'd0}, 6, stalls);
        drain();
        out_ready = 1'b0;
        send_word({3'd1, 18'd0}, 6, stalls);
        for (int k = 0; k < 3; k++) put(3'd5, 1'b0, st);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_drops_out_valid", 32'(out_valid), 0);
        check("reset_clears_syn_out", 32'(syn_out), 0);
        out_ready = 1'b1;
        push(12'h000, 1'b1, 1'b0);
        send_word(21'd0, 6, stalls);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
